debounce_bank: RTL and testbench
================================

# debounce_bank

Debounces and edge-detects a bank of raw mechanical inputs (buttons/switches) using the 5 kHz sample-tick pulse produced by the block upstream. Sits between the board pins and the register I/O logic, supplying clean levels plus one-cycle press/release strobes on the 25 MHz domain. Each channel accepts a new level only after STABLE_TICKS consecutive agreeing tick samples.

## Interface
- N, default 4: number of independent input channels (≥1).
- STABLE_TICKS, default 25: consecutive agreeing tick samples required to accept a new level (≥1; 25 = 5 ms at 5 kHz).
- clk25mhz  input  1  system clock, 25 MHz; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pulse5khz  input  1  sample tick, high for exactly one clk25mhz cycle per tick period.
- btn_raw  input  N  asynchronous raw inputs, active-high.
- btn_level  output  N  debounced level per channel.
- btn_press  output  N  one-cycle strobe on accepted 0→1.
- btn_release  output  N  one-cycle strobe on accepted 1→0.

## Operation
- Every channel: 2-flop synchronizer on clk25mhz (reset to 0), then a 4-state FSM and a tick counter of width $clog2(STABLE_TICKS+1).
- FSM acts only on cycles where pulse5khz=1; on other cycles state, counter and btn_level hold, strobes are 0.
- States: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW. Sample s = synchronized bit.
- IDLE_LOW, tick, s=1: count←1; if STABLE_TICKS=1 commit high immediately, else →CHECK_HIGH. s=0: stay.
- CHECK_HIGH, tick, s=1: count+1; when count+1 = STABLE_TICKS, commit: →IDLE_HIGH, btn_level←1, btn_press pulses. s=0: →IDLE_LOW, count←0, no strobe.
- IDLE_HIGH / CHECK_LOW: mirror image, committing btn_level←0 with btn_release.
- Counter never exceeds STABLE_TICKS; cleared on every commit and abort.
- Changes of btn_raw lasting entirely between two ticks are invisible and produce no output.
- Channels fully independent; simultaneous commits on several channels assert their strobes in the same cycle.
- btn_press and btn_release of one channel are never high together.

## Timing
- Reset (async assert, sync release): all synchronizer flops 0, all FSMs IDLE_LOW, counters 0, btn_level=0, btn_press=0, btn_release=0.
- Reset mid-check abandons progress; afterwards the channel restarts from IDLE_LOW.
- Input held high across reset deassertion is treated as a fresh press: btn_press fires after STABLE_TICKS ticks.
- Synchronizer latency: 2 clk25mhz cycles from btn_raw to s.
- Commit: btn_level and strobe registered on the clock edge sampling the STABLE_TICKS-th agreeing tick; visible the following cycle. Strobe high exactly 1 cycle.
- Accept latency: STABLE_TICKS ticks after the first tick seeing the new value (≈5 ms default).
- pulse5khz assumed single-cycle; if held high, each high cycle counts as a tick.

## Structure
- Shared package reg_io_pkg: state encoding localparams (IDLE_LOW=2'd0, CHECK_HIGH=2'd1, IDLE_HIGH=2'd2, CHECK_LOW=2'd3), shared with other reg_io blocks.
- Sub-module debounce_chan: one channel (synchronizer, FSM, counter, strobes), parameterized by STABLE_TICKS; debounce_bank instantiates N copies via generate.
- Elaboration-time check: STABLE_TICKS ≥1 and N ≥1, else $error.

## Test plan
Bench: N=4, STABLE_TICKS=4, pulse5khz modelled as 1 cycle high every 10 clk25mhz cycles.
- Reset: assert reset with btn_raw=4'hF mid-run → all outputs 0 within same cycle; after release, btn_level=4'hF only after 4 ticks, btn_press=4'hF for exactly 1 cycle.
- Clean press/release ch0: raw[0] 0→1 held 8 ticks → btn_level[0]=1 after 4th tick, btn_press=4'b0001 one cycle; then 1→0 → btn_release=4'b0001 one cycle after 4 ticks.
- Bounce ch2: raw[2] samples 1,0,1,1,0,1,1,1,1 across ticks → exactly one btn_press[2], on the 9th tick; no release.
- Sub-tick glitch: raw[1] high for 3 cycles between ticks → no output change on any channel.
- Simultaneous: raw[1] and raw[3] rise same cycle → btn_press=4'b1010 in one cycle.
- Reset mid-check: raw[0] high, reset after 2 ticks → btn_level[0]=0, count lost; press fires 4 ticks after reset release, not 2.

Source files
------------

// File: rtl/reg_io_pkg.sv
// Shared definitions for the reg_io block family.
// Holds the four-state encoding used by the per-channel debounce FSM.
package reg_io_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } db_state_e;

endpackage

// File: rtl/debounce_bank_if.sv
// Sample tick, raw pins and debounced results of a debounce bank.
// The master side drives the tick and pins, and the slave side (the bank) drives the results.
interface debounce_bank_if #(
    parameter int unsigned N = 4
);
    logic         pulse5khz;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    modport master (
        output pulse5khz, btn_raw,
        input  btn_level, btn_press, btn_release
    );

    modport slave (
        input  pulse5khz, btn_raw,
        output btn_level, btn_press, btn_release
    );
endinterface

// File: rtl/debounce_chan.sv
// One debounce channel. It has a 2-flop synchronizer, a tick-qualified accept FSM with an agreement counter,
// and registered level, press and release outputs.
module debounce_chan
    import reg_io_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 25
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_TGT = CW'(STABLE_TICKS);

    logic [1:0]    sync_q;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          s;
    logic [CW-1:0] cnt_inc;

    assign s       = sync_q[1];
    assign cnt_inc = cnt_q + CNT_ONE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b00;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    // Next-state logic. A single-tick configuration commits directly from the idle states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (tick_i) begin
            unique case (state_q)
                IDLE_LOW: begin
                    if (s) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = IDLE_HIGH;
                            level_d = 1'b1;
                            press_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = CHECK_HIGH;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                CHECK_HIGH: begin
                    if (!s) begin
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_TGT) begin
                        state_d = IDLE_HIGH;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = IDLE_LOW;
                            level_d = 1'b0;
                            rel_d   = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = CHECK_LOW;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                CHECK_LOW: begin
                    if (s) begin
                        state_d = IDLE_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_TGT) begin
                        state_d = IDLE_LOW;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
endmodule

// File: rtl/debounce_bank.sv
// Bank of N independent debounce channels that share one sample tick.
module debounce_bank #(
    parameter int unsigned N            = 4,
    parameter int unsigned STABLE_TICKS = 25
) (
    input  logic           clk25mhz,
    input  logic           reset,
    debounce_bank_if.slave bus
);
    if (N == 0 || STABLE_TICKS == 0) begin : g_bad_param
        $error("debounce_bank: N and STABLE_TICKS must both be >= 1");
    end

    for (genvar i = 0; i < int'(N); i++) begin : g_chan
        debounce_chan #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .clk_i    (clk25mhz),
            .rst_i    (reset),
            .tick_i   (bus.pulse5khz),
            .raw_i    (bus.btn_raw[i]),
            .level_o  (bus.btn_level[i]),
            .press_o  (bus.btn_press[i]),
            .release_o(bus.btn_release[i])
        );
    end
endmodule

// File: tb/tb_debounce_bank.sv
// Testbench for debounce_bank. A run-length model of the accept rule is checked every cycle,
// and directed and random scenarios are pinned with literal expectations.
module tb_debounce_bank;
    localparam int unsigned N           = 4;
    localparam int unsigned ST          = 4;
    localparam int          TICK_PERIOD = 10;

    logic clk = 1'b0;
    logic rst;
    always #20 clk = ~clk;

    debounce_bank_if #(.N(N)) bus ();

    debounce_bank #(.N(N), .STABLE_TICKS(ST)) dut (
        .clk25mhz(clk),
        .reset   (rst),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int tick_no = 0;
    logic         rst_v = 1'b1;
    logic [N-1:0] raw_v = '0;

    // Reference: raw delayed two clocks, then a per-channel run of disagreeing tick samples
    logic [N-1:0] m_d0, m_d1, m_level, m_press, m_rel;
    int           m_run[N];

    always @(posedge clk) begin : model
        if (rst) begin
            m_d0 = '0; m_d1 = '0; m_level = '0; m_press = '0; m_rel = '0;
            for (int c = 0; c < int'(N); c++) m_run[c] = 0;
        end else begin
            m_press = '0;
            m_rel   = '0;
            if (bus.pulse5khz) begin
                for (int c = 0; c < int'(N); c++) begin
                    if (m_d1[c] != m_level[c]) begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] == int'(ST)) begin
                            m_level[c] = m_d1[c];
                            if (m_d1[c]) m_press[c] = 1'b1;
                            else         m_rel[c]   = 1'b1;
                            m_run[c] = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
            end
            m_d1 = m_d0;
            m_d0 = bus.btn_raw;
        end
    end

    int           press_cnt[N];
    int           rel_cnt[N];
    int           press_tick[N];
    int           press_cycles;
    logic [N-1:0] press_val;

    task automatic clear_obs();
        for (int c = 0; c < int'(N); c++) begin
            press_cnt[c] = 0; rel_cnt[c] = 0; press_tick[c] = -1;
        end
        press_cycles = 0;
        press_val    = '0;
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: compare at the falling edge, record strobes, then drive the next inputs
    task automatic step();
        @(negedge clk);
        check("level", bus.btn_level, m_level);
        check("press", bus.btn_press, m_press);
        check("release", bus.btn_release, m_rel);
        for (int c = 0; c < int'(N); c++) begin
            if (bus.btn_press[c] === 1'b1) begin
                press_cnt[c]++;
                press_tick[c] = tick_no;
            end
            if (bus.btn_release[c] === 1'b1) rel_cnt[c]++;
        end
        if (bus.btn_press != '0) begin
            press_cycles++;
            press_val = bus.btn_press;
        end
        rst           = rst_v;
        bus.btn_raw   = raw_v;
        bus.pulse5khz = ((cyc % TICK_PERIOD) == TICK_PERIOD - 1);
        if (bus.pulse5khz) tick_no++;
        cyc++;
    endtask

    task automatic run_ticks(input int n);
        int seen = 0;
        while (seen < n) begin
            step();
            if (bus.pulse5khz) seen++;
        end
    endtask

    task automatic check_reset_now();
        #1;
        check("async_reset_level", bus.btn_level, '0);
        check("async_reset_press", bus.btn_press, '0);
        check("async_reset_release", bus.btn_release, '0);
    endtask

    int t0;
    logic [N-1:0] bounce_q[$];

    initial begin
        rst = 1'b1;
        bus.btn_raw   = '0;
        bus.pulse5khz = 1'b0;
        clear_obs();
        repeat (4) step();
        check("reset_level", bus.btn_level, '0);
        check("reset_press", bus.btn_press, '0);

        // Reset asserted mid-run with every input high, then a fresh press after release
        rst_v = 1'b0;
        raw_v = 4'hF;
        run_ticks(6);
        step();
        check("all_high", bus.btn_level, 4'hF);
        rst_v = 1'b1;
        step();
        check_reset_now();
        run_ticks(1);
        rst_v = 1'b0;
        clear_obs();
        t0 = tick_no;
        run_ticks(3);
        step();
        check("rst_3ticks_low", bus.btn_level, 4'h0);
        run_ticks(3);
        step();
        check("rst_fresh_level", bus.btn_level, 4'hF);
        check_int("rst_press_cycles", press_cycles, 1);
        check("rst_press_val", press_val, 4'hF);
        check_int("rst_press_tick", press_tick[0] - t0, 4);

        // Clean press and release on channel 0
        raw_v = 4'h0;
        run_ticks(6);
        clear_obs();
        t0 = tick_no;
        raw_v[0] = 1'b1;
        run_ticks(3);
        step();
        check("ch0_before_accept", bus.btn_level, 4'b0000);
        run_ticks(5);
        step();
        check("ch0_level_high", bus.btn_level, 4'b0001);
        check_int("ch0_press_cycles", press_cnt[0], 1);
        check_int("ch0_press_tick", press_tick[0] - t0, 4);
        clear_obs();
        raw_v[0] = 1'b0;
        run_ticks(8);
        step();
        check("ch0_level_low", bus.btn_level, 4'b0000);
        check_int("ch0_release_cycles", rel_cnt[0], 1);
        check_int("ch0_no_press", press_cnt[0], 0);

        // Bouncing channel 2 accepted only on the 9th tick
        clear_obs();
        t0 = tick_no;
        bounce_q = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
        foreach (bounce_q[k]) begin
            raw_v[2] = bounce_q[k][0];
            run_ticks(1);
        end
        repeat (3) step();
        check("ch2_level", bus.btn_level, 4'b0100);
        check_int("ch2_press_cycles", press_cnt[2], 1);
        check_int("ch2_press_tick", press_tick[2] - t0, 9);
        check_int("ch2_no_release", rel_cnt[2], 0);

        // Glitch on channel 1 that falls entirely between two ticks
        clear_obs();
        run_ticks(1);
        repeat (3) step();
        raw_v[1] = 1'b1;
        repeat (3) step();
        raw_v[1] = 1'b0;
        run_ticks(5);
        step();
        check("glitch_level", bus.btn_level, 4'b0100);
        check_int("glitch_no_press", press_cycles, 0);

        // Channels 1 and 3 rising in the same cycle
        clear_obs();
        raw_v[1] = 1'b1;
        raw_v[3] = 1'b1;
        run_ticks(5);
        step();
        check("simul_press_val", press_val, 4'b1010);
        check_int("simul_press_cycles", press_cycles, 1);
        check("simul_level", bus.btn_level, 4'b1110);

        // Reset in the middle of a check discards the progress made so far
        raw_v = 4'h0;
        run_ticks(6);
        raw_v[0] = 1'b1;
        run_ticks(2);
        rst_v = 1'b1;
        step();
        check_reset_now();
        run_ticks(1);
        rst_v = 1'b0;
        clear_obs();
        t0 = tick_no;
        run_ticks(6);
        step();
        check_int("midchk_press_tick", press_tick[0] - t0, 4);
        check("midchk_level", bus.btn_level, 4'b0001);

        // Random pin activity with occasional resets, checked against the model every cycle
        for (int k = 0; k < 5000; k++) begin
            if ($urandom_range(0, 29) == 0) raw_v[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 1999) == 0) rst_v = 1'b1;
            else if (rst_v && $urandom_range(0, 2) == 0) rst_v = 1'b0;
            step();
        end
        rst_v = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
